store_drain_buffer: RTL and testbench

//  D-cache-side responder for the store queue's retired-store request stream (store_req_valid/accepted).

---
 rtl/store_drain_buffer.sv | 211 +++++++++++++++++++++
 tb/tb_store_drain_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_buffer.sv
// store_drain_buffer
//   Write-combining buffer between the store queue and memory. Retired word
//   stores are merged into 8-byte block entries held in a circular FIFO; the
//   oldest entry is drained to memory (read-modify-write when the block is not
//   fully written). Buffered bytes are forwarded to the load unit.
//
//   Ports
//     clock, reset              clock; synchronous active-low reset
//     store_req_*               store request stream (valid/addr/data/byte_mask)
//     store_req_accepted        store consumed this cycle
//     load_req_addr             load lookup address
//     wcb_load_data/data_mask   forwarded bytes and the byte-valid mask
//     proc2mem_*                memory command/address/data
//     mem2proc_*                memory accept tag, data tag, returning data
//     wcb_empty                 no valid entries and drain machine idle
//     drain_state               drain machine state (0 IDLE, 1 LD_REQ, 2 LD_WAIT, 3 ST_REQ)
//
//   Handshake: a store transfers on a clock edge where store_req_valid and
//   store_req_accepted are both high. store_req_accepted is combinational and
//   may be high only while store_req_valid is high; the requester holds the
//   request stable until it is accepted.
module store_drain_buffer #(
   parameter int WCB_SZ   = 4,
   parameter int WCB_BITS = $clog2(WCB_SZ)
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        store_req_valid,
   input  logic [31:0] store_req_addr,
   input  logic [31:0] store_req_data,
   input  logic [3:0]  store_req_byte_mask,
   output logic        store_req_accepted,
   input  logic [31:0] load_req_addr,
   output logic [31:0] wcb_load_data,
   output logic [3:0]  wcb_data_mask,
   output logic [1:0]  proc2mem_command,
   output logic [31:0] proc2mem_addr,
   output logic [63:0] proc2mem_data,
   input  logic [3:0]  mem2proc_transaction_tag,
   input  logic [3:0]  mem2proc_data_tag,
   input  logic [63:0] mem2proc_data,
   output logic        wcb_empty,
   output logic [1:0]  drain_state
);
   localparam logic [1:0] MEM_NONE  = 2'd0;
   localparam logic [1:0] MEM_LOAD  = 2'd1;
   localparam logic [1:0] MEM_STORE = 2'd2;

   typedef enum logic [1:0] {IDLE, LD_REQ, LD_WAIT, ST_REQ} drain_t;
   drain_t state, state_next;

   logic [WCB_SZ-1:0]   ent_valid;
   logic [28:0]         ent_blk  [WCB_SZ];
   logic [63:0]         ent_data [WCB_SZ];
   logic [7:0]          ent_mask [WCB_SZ];
   logic [WCB_BITS:0]   head, tail;
   logic [WCB_BITS-1:0] head_idx, tail_idx;
   logic [3:0]          tag_q;
   logic                full;

   // Address bits [1:0] are not used: requests are word granular.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{store_req_addr[1:0], load_req_addr[1:0]};

   assign head_idx = head[WCB_BITS-1:0];
   assign tail_idx = tail[WCB_BITS-1:0];
   // Same slot index with differing wrap parity means the ring is full.
   assign full = (head_idx == tail_idx) && (head[WCB_BITS] != tail[WCB_BITS]);

   function automatic logic [63:0] expand(input logic [7:0] m);
      logic [63:0] e;
      for (int b = 0; b < 8; b++) e[b*8 +: 8] = {8{m[b]}};
      return e;
   endfunction

   // Place the word store into its half of the block.
   logic [28:0] req_blk;
   logic [7:0]  req_mask8;
   logic [63:0] req_data64;
   assign req_blk    = store_req_addr[31:3];
   assign req_mask8  = store_req_addr[2] ? {store_req_byte_mask, 4'b0} : {4'b0, store_req_byte_mask};
   assign req_data64 = store_req_addr[2] ? {store_req_data, 32'b0} : {32'b0, store_req_data};

   // The head entry stops accepting merges once the drain machine has left
   // IDLE; a store to that block then opens a fresh entry, so at most one
   // mergeable entry can match.
   logic                merge_hit;
   logic [WCB_BITS-1:0] merge_idx;
   always_comb begin
      merge_hit = 1'b0;
      merge_idx = '0;
      for (int i = 0; i < WCB_SZ; i++) begin
         if (ent_valid[i] && (ent_blk[i] == req_blk) &&
             !((WCB_BITS'(i) == head_idx) && (state != IDLE))) begin
            merge_hit = 1'b1;
            merge_idx = WCB_BITS'(i);
         end
      end
   end

   logic do_merge, do_alloc;
   assign store_req_accepted = store_req_valid && (merge_hit || !full);
   assign do_merge = store_req_accepted && merge_hit;
   assign do_alloc = store_req_accepted && !merge_hit;

   // Drain machine: next state and memory interface.
   logic latch_tag, fill_head, free_head;
   always_comb begin
      state_next       = state;
      proc2mem_command = MEM_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      latch_tag        = 1'b0;
      fill_head        = 1'b0;
      free_head        = 1'b0;
      case (state)
         IDLE: begin
            if (ent_valid[head_idx])
               state_next = (ent_mask[head_idx] == 8'hFF) ? ST_REQ : LD_REQ;
         end
         LD_REQ: begin
            proc2mem_command = MEM_LOAD;
            proc2mem_addr    = {ent_blk[head_idx], 3'b000};
            if (mem2proc_transaction_tag != 4'd0) begin
               latch_tag  = 1'b1;
               state_next = LD_WAIT;
            end
         end
         LD_WAIT: begin
            if ((mem2proc_data_tag != 4'd0) && (mem2proc_data_tag == tag_q)) begin
               fill_head  = 1'b1;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            proc2mem_command = MEM_STORE;
            proc2mem_addr    = {ent_blk[head_idx], 3'b000};
            proc2mem_data    = ent_data[head_idx];
            if (mem2proc_transaction_tag != 4'd0) begin
               free_head  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         head      <= '0;
         tail      <= '0;
         tag_q     <= '0;
         ent_valid <= '0;
         for (int i = 0; i < WCB_SZ; i++) begin
            ent_blk[i]  <= '0;
            ent_data[i] <= '0;
            ent_mask[i] <= '0;
         end
      end else begin
         state <= state_next;
         if (latch_tag) tag_q <= mem2proc_transaction_tag;
         // Memory fills only the bytes no store has written; mask is kept so
         // forwarding still reports store bytes only.
         if (fill_head)
            ent_data[head_idx] <= (ent_data[head_idx] & expand(ent_mask[head_idx])) |
                                  (mem2proc_data & ~expand(ent_mask[head_idx]));
         if (do_merge) begin
            ent_data[merge_idx] <= (ent_data[merge_idx] & ~expand(req_mask8)) |
                                   (req_data64 & expand(req_mask8));
            ent_mask[merge_idx] <= ent_mask[merge_idx] | req_mask8;
         end
         if (do_alloc) begin
            ent_valid[tail_idx] <= 1'b1;
            ent_blk[tail_idx]   <= req_blk;
            ent_data[tail_idx]  <= req_data64;
            ent_mask[tail_idx]  <= req_mask8;
            tail                <= tail + (WCB_BITS+1)'(1);
         end
         if (free_head) begin
            ent_valid[head_idx] <= 1'b0;
            head                <= head + (WCB_BITS+1)'(1);
         end
      end
   end

   // Forwarding: walk entries oldest to youngest so the youngest match wins.
   logic [WCB_BITS-1:0] fwd_idx;
   logic [2:0]          fwd_lane;
   always_comb begin
      wcb_load_data = '0;
      wcb_data_mask = '0;
      fwd_idx       = '0;
      fwd_lane      = '0;
      for (int k = 0; k < WCB_SZ; k++) begin
         fwd_idx = head_idx + WCB_BITS'(k);
         if (ent_valid[fwd_idx] && (ent_blk[fwd_idx] == load_req_addr[31:3])) begin
            for (int b = 0; b < 4; b++) begin
               fwd_lane = {load_req_addr[2], 2'(b)};
               if (ent_mask[fwd_idx][fwd_lane]) begin
                  wcb_data_mask[b]       = 1'b1;
                  wcb_load_data[b*8 +: 8] = ent_data[fwd_idx][{fwd_lane, 3'b000} +: 8];
               end
            end
         end
      end
   end

   assign wcb_empty   = (head == tail) && (state == IDLE);
   assign drain_state = state;
endmodule

// File: tb/tb_store_drain_buffer.sv
// tb_store_drain_buffer
//   Directed and randomized checks of store_drain_buffer against a byte-level
//   memory model: golden memory after all stores, a list of buffered stores
//   for forwarding, and a log of memory commands granted by the bench memory.
module tb_store_drain_buffer;
   localparam logic [1:0] MEM_NONE  = 2'd0;
   localparam logic [1:0] MEM_LOAD  = 2'd1;
   localparam logic [1:0] MEM_STORE = 2'd2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        store_req_valid = 1'b0;
   logic [31:0] store_req_addr = '0;
   logic [31:0] store_req_data = '0;
   logic [3:0]  store_req_byte_mask = '0;
   logic        store_req_accepted;
   logic [31:0] load_req_addr = '0;
   logic [31:0] wcb_load_data;
   logic [3:0]  wcb_data_mask;
   logic [1:0]  proc2mem_command;
   logic [31:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [3:0]  mem2proc_transaction_tag = '0;
   logic [3:0]  mem2proc_data_tag = '0;
   logic [63:0] mem2proc_data = '0;
   logic        wcb_empty;
   logic [1:0]  drain_state;

   store_drain_buffer dut (
      .clock(clock), .reset(reset),
      .store_req_valid(store_req_valid), .store_req_addr(store_req_addr),
      .store_req_data(store_req_data), .store_req_byte_mask(store_req_byte_mask),
      .store_req_accepted(store_req_accepted), .load_req_addr(load_req_addr),
      .wcb_load_data(wcb_load_data), .wcb_data_mask(wcb_data_mask),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data), .mem2proc_transaction_tag(mem2proc_transaction_tag),
      .mem2proc_data_tag(mem2proc_data_tag), .mem2proc_data(mem2proc_data),
      .wcb_empty(wcb_empty), .drain_state(drain_state)
   );

   // ---------------- clock / watchdog ----------------
   initial forever #5 clock = ~clock;
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int n_vec  = 0;
   int n_miss = 0;

   typedef struct packed {logic [1:0] cmd; logic [31:0] addr; logic [63:0] data;} mem_op_t;
   typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [3:0] mask;} st_t;
   mem_op_t     log_q[$];
   st_t         pend_q[$];
   logic [31:0] exp_q[$];
   logic [63:0] mem  [logic [28:0]];
   logic [63:0] gold [logic [28:0]];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] init_blk(input logic [28:0] b);
      logic [31:0] w;
      w = {3'b0, b};
      return {~w, w ^ 32'hA5A5_A5A5};
   endfunction
   function automatic logic [63:0] rd_mem(input logic [28:0] b);
      return mem.exists(b) ? mem[b] : init_blk(b);
   endfunction
   function automatic logic [63:0] rd_gold(input logic [28:0] b);
      return gold.exists(b) ? gold[b] : init_blk(b);
   endfunction
   function automatic int n_cmd(input logic [1:0] c);
      int n = 0;
      foreach (log_q[i]) if (log_q[i].cmd == c) n++;
      return n;
   endfunction

   // ---------------- memory responder ----------------
   bit          mem_stall = 1'b0;
   bit          ld_hold   = 1'b0;
   int          grant_pct = 100;
   bit          ld_busy   = 1'b0;
   logic [3:0]  ld_tag    = '0;
   logic [3:0]  next_tag  = 4'd1;
   logic [28:0] ld_blk    = '0;
   int          ld_pend   = 0;
   initial begin
      mem_op_t op;
      forever begin
         @(negedge clock);
         mem2proc_transaction_tag = '0;
         mem2proc_data_tag        = '0;
         mem2proc_data            = '0;
         if (ld_busy) begin
            if (!ld_hold) begin
               if (ld_pend > 0) ld_pend--;
               else begin
                  mem2proc_data_tag = ld_tag;
                  mem2proc_data     = rd_mem(ld_blk);
                  ld_busy           = 1'b0;
               end
            end
         end else if (!mem_stall && proc2mem_command != MEM_NONE &&
                      $urandom_range(1, 100) <= grant_pct) begin
            mem2proc_transaction_tag = next_tag;
            op.cmd = proc2mem_command; op.addr = proc2mem_addr; op.data = proc2mem_data;
            log_q.push_back(op);
            if (proc2mem_command == MEM_LOAD) begin
               ld_busy = 1'b1;
               ld_tag  = next_tag;
               ld_blk  = proc2mem_addr[31:3];
               ld_pend = $urandom_range(0, 3);
            end else begin
               mem[proc2mem_addr[31:3]] = proc2mem_data;
            end
            next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      store_req_valid = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      pend_q.delete();
   endtask

   // Holds the request up to max_cyc cycles; exp_acc < 0 skips the first-cycle check.
   task automatic put_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                            input int exp_acc, input int max_cyc, output bit acc);
      logic [63:0] g;
      st_t s;
      acc = 1'b0;
      for (int i = 0; i < max_cyc && !acc; i++) begin
         @(negedge clock);
         store_req_valid = 1'b1; store_req_addr = a; store_req_data = d; store_req_byte_mask = m;
         #1;
         acc = store_req_accepted;
         if (i == 0 && exp_acc >= 0) check($sformatf("accept_%h", a), acc, exp_acc[0]);
         @(posedge clock);
      end
      #1 store_req_valid = 1'b0;
      if (acc) begin
         g = rd_gold(a[31:3]);
         for (int b = 0; b < 4; b++)
            if (m[b]) g[((a[2] ? 4 : 0) + b)*8 +: 8] = d[b*8 +: 8];
         gold[a[31:3]] = g;
         s.addr = a; s.data = d; s.mask = m;
         pend_q.push_back(s);
      end
   endtask

   // Expected forwarding: youngest buffered store wins per byte.
   task automatic fwd_check(input logic [31:0] a);
      logic [31:0] ed = '0;
      logic [3:0]  em = '0;
      foreach (pend_q[i])
         if (pend_q[i].addr[31:2] == a[31:2])
            for (int b = 0; b < 4; b++)
               if (pend_q[i].mask[b]) begin
                  em[b] = 1'b1;
                  ed[b*8 +: 8] = pend_q[i].data[b*8 +: 8];
               end
      @(negedge clock);
      load_req_addr = a;
      #1;
      check($sformatf("fwd_mask_%h", a), wcb_data_mask, em);
      check($sformatf("fwd_data_%h", a), wcb_load_data, ed);
   endtask

   task automatic wait_empty(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clock); #1;
         if (wcb_empty) break;
      end
      check("drain_done", wcb_empty, 1'b1);
      pend_q.delete();
   endtask

   task automatic wait_load(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clock); #1;
         if (n_cmd(MEM_LOAD) > 0) break;
      end
      check("load_issued", n_cmd(MEM_LOAD) > 0, 1'b1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      bit          acc;
      logic [31:0] e;
      logic [31:0] a;
      int          nst;

      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("rst_accepted", store_req_accepted, 1'b0);
      check("rst_command", proc2mem_command, MEM_NONE);
      check("rst_addr", proc2mem_addr, 32'h0);
      check("rst_data", proc2mem_data, 64'h0);
      check("rst_fwd_mask", wcb_data_mask, 4'h0);
      check("rst_empty", wcb_empty, 1'b1);
      check("rst_state", drain_state, 2'd0);

      // Partial store -> read-modify-write.
      mem[29'h200]  = 64'h1122_3344_5566_7788;
      gold[29'h200] = 64'h1122_3344_5566_7788;
      log_q.delete();
      put_store(32'h1000, 32'hDEAD_BEEF, 4'hF, 1, 1, acc);
      wait_empty(200);
      check("t1_ops", log_q.size(), 2);
      check("t1_ld_cmd", log_q[0].cmd, MEM_LOAD);
      check("t1_ld_addr", log_q[0].addr, 32'h1000);
      check("t1_st_cmd", log_q[1].cmd, MEM_STORE);
      check("t1_st_addr", log_q[1].addr, 32'h1000);
      check("t1_st_data", log_q[1].data, 64'h1122_3344_DEAD_BEEF);

      // Two words merge into one full block while the head is busy elsewhere.
      log_q.delete();
      mem_stall = 1'b1;
      put_store(32'h5000, 32'h1234_5678, 4'hF, 1, 1, acc);
      repeat (3) @(posedge clock);
      put_store(32'h2000, 32'hAAAA_0001, 4'hF, 1, 1, acc);
      put_store(32'h2004, 32'hBBBB_0002, 4'hF, 1, 1, acc);
      fwd_check(32'h2000);
      fwd_check(32'h2004);
      mem_stall = 1'b0;
      wait_empty(300);
      check("t2_ops", log_q.size(), 3);
      check("t2_loads", n_cmd(MEM_LOAD), 1);
      check("t2_st5000_data", log_q[1].data, rd_gold(29'h0A00));
      check("t2_st2000_addr", log_q[2].addr, 32'h2000);
      check("t2_st2000_data", log_q[2].data, 64'hBBBB_0002_AAAA_0001);

      // Fill every entry with memory stalled; pointer wrap on the next allocation.
      do_reset();
      log_q.delete();
      mem_stall = 1'b1;
      put_store(32'h6000, 32'h6000_0000, 4'hF, 1, 1, acc);
      repeat (2) @(posedge clock);
      put_store(32'h6008, 32'h6008_0000, 4'hF, 1, 1, acc);
      put_store(32'h6010, 32'h6010_0000, 4'hF, 1, 1, acc);
      put_store(32'h6018, 32'h6018_0000, 4'hF, 1, 1, acc);
      for (int i = 0; i < 3; i++) put_store(32'h6020, 32'h6020_0000, 4'hF, 0, 1, acc);
      put_store(32'h600C, 32'h600C_0000, 4'hF, 1, 1, acc);
      put_store(32'h6004, 32'h6004_0000, 4'hF, 0, 1, acc);
      fwd_check(32'h6008);
      fwd_check(32'h600C);
      fwd_check(32'h6004);
      for (int i = 0; i < 5; i++) exp_q.push_back(32'h6000 + 32'(i*8));
      mem_stall = 1'b0;
      put_store(32'h6020, 32'h6020_0000, 4'hF, -1, 500, acc);
      check("t3_accept_after_free", acc, 1'b1);
      check("t3_store_before_accept", n_cmd(MEM_STORE) >= 1, 1'b1);
      wait_empty(1000);
      foreach (log_q[i]) begin
         if (log_q[i].cmd == MEM_STORE) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            check("t3_drain_order", log_q[i].addr, e);
         end
      end
      check("t3_drain_left", exp_q.size(), 0);
      for (int i = 0; i < 5; i++) begin
         a = 32'h6000 + 32'(i*8);
         check($sformatf("t3_mem_%h", a), rd_mem(a[31:3]), rd_gold(a[31:3]));
      end

      // Byte forwarding, then a younger entry for the block in LD_WAIT.
      log_q.delete();
      mem_stall = 1'b1;
      put_store(32'h3000, 32'h0000_AB00, 4'b0010, 1, 1, acc);
      repeat (2) @(posedge clock);
      fwd_check(32'h3000);
      check("t4_fwd_mask_const", wcb_data_mask, 4'b0010);
      check("t4_fwd_data_const", wcb_load_data, 32'h0000_AB00);
      fwd_check(32'h3004);
      ld_hold   = 1'b1;
      mem_stall = 1'b0;
      wait_load(50);
      put_store(32'h3000, 32'h00CD_EF00, 4'b0110, 1, 1, acc);
      fwd_check(32'h3000);
      ld_hold = 1'b0;
      wait_empty(400);
      check("t4_ops", log_q.size(), 4);
      check("t4_stores", n_cmd(MEM_STORE), 2);
      check("t4_op1_cmd", log_q[1].cmd, MEM_STORE);
      check("t4_first_byte", log_q[1].data[15:8], 8'hAB);
      check("t4_op3_cmd", log_q[3].cmd, MEM_STORE);
      check("t4_mem", rd_mem(29'h600), rd_gold(29'h600));

      // Reset while a load is outstanding; the late data must be ignored.
      log_q.delete();
      ld_hold = 1'b1;
      put_store(32'h4000, 32'h0000_00CC, 4'b0001, 1, 1, acc);
      wait_load(50);
      do_reset();
      ld_hold = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock); #1;
         check("t5_empty", wcb_empty, 1'b1);
         check("t5_command", proc2mem_command, MEM_NONE);
      end
      fwd_check(32'h4000);

      // Random stores over a few blocks with random memory acceptance/latency.
      grant_pct = 50;
      for (int n = 0; n < 250; n++) begin
         a = 32'h8000 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 1) * 4);
         put_store(a, $urandom, 4'($urandom_range(1, 15)), -1, 200, acc);
         check("rand_accept", acc, 1'b1);
         repeat ($urandom_range(0, 2)) @(posedge clock);
      end
      grant_pct = 100;
      wait_empty(3000);
      for (int i = 0; i < 8; i++) begin
         a = 32'h8000 + 32'(i*8);
         check($sformatf("rand_mem_%h", a), rd_mem(a[31:3]), rd_gold(a[31:3]));
      end
      nst = n_cmd(MEM_STORE);
      check("rand_some_stores", nst > 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
